// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_responder
// Purpose  : SDR SDRAM device model: init FSM, bank tracking, CL 2/3 reads,
//            byte-masked writes, sticky protocol error reporting.
//            Optional: SDRAM_RESPONDER_TIMING_CHECK_EN adds tRCD/tRP checks.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_responder #(
  parameter int MEM_AW = 10,
  parameter int TRCD   = 2,
  parameter int TRP    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [12:0] a,
  input  logic [1:0]  ba,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic        cke,
  input  logic [1:0]  dm,
  inout  wire  [15:0] dq,
  output logic        ready,
  output logic        err,
  output logic [3:0]  err_code
);

  localparam logic [1:0] ST_INIT_PRE = 2'd0;
  localparam logic [1:0] ST_INIT_REF = 2'd1;
  localparam logic [1:0] ST_INIT_MRS = 2'd2;
  localparam logic [1:0] ST_READY    = 2'd3;

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;

  // Index formation supports at most the full {ba,row,col} width.
  if (MEM_AW > 24 || TRCD < 0 || TRP < 0) begin : g_unsupported_params
  end

  logic [1:0]        state_q, state_d;
  logic              ref_seen_q, ref_seen_d;
  logic [1:0]        cl_q, cl_d;
  logic              err_q, err_d;
  logic [3:0]        err_code_q, err_code_d;
  logic [3:0]        open_q, open_d;
  logic [3:0][12:0]  row_q, row_d;
  logic [2:0]        rd_vld_q, rd_vld_d;
  logic [2:0][15:0]  rd_data_q, rd_data_d;
  logic [2:0][1:0]   rd_mask_q, rd_mask_d;
  logic [15:0]       mem_q [1 << MEM_AW];

  logic              cmd_vld;
  logic [2:0]        cmd;
  logic              is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
  logic              mrs_ok, in_ready;
  logic              flag;
  logic [3:0]        flag_code;
  logic              mem_we, mem_re;
  logic [MEM_AW-1:0] word_idx;
  logic [15:0]       rd_word;

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TRCD_LOAD = (TRCD > 1) ? CNT_W'(TRCD - 1) : '0;
  localparam logic [CNT_W-1:0] TRP_LOAD  = (TRP > 1)  ? CNT_W'(TRP - 1)  : '0;
  logic [3:0][CNT_W-1:0] trcd_cnt_q, trcd_cnt_d, trp_cnt_q, trp_cnt_d;
`endif

  always_comb begin
    cmd     = {ras_n, cas_n, we_n};
    cmd_vld = cke & ~cs_n;
    is_act  = cmd_vld && (cmd == CMD_ACT);
    is_rd   = cmd_vld && (cmd == CMD_RD);
    is_wr   = cmd_vld && (cmd == CMD_WR);
    is_pre  = cmd_vld && (cmd == CMD_PRE);
    is_ref  = cmd_vld && (cmd == CMD_REF);
    is_mrs  = cmd_vld && (cmd == CMD_MRS);
    mrs_ok  = (a[3:0] == 4'b0000) && ((a[6:4] == 3'd2) || (a[6:4] == 3'd3));
    in_ready = (state_q == ST_READY);
  end

  assign word_idx = MEM_AW'({ba, row_q[ba], a[8:0]});
  assign rd_word  = mem_q[word_idx];

  // Init FSM: next state
  always_comb begin
    state_d    = state_q;
    ref_seen_d = ref_seen_q;
    case (state_q)
      ST_INIT_PRE: if (is_pre && a[10]) state_d = ST_INIT_REF;
      ST_INIT_REF: if (is_ref) begin
        ref_seen_d = ~ref_seen_q;
        if (ref_seen_q) state_d = ST_INIT_MRS;
      end
      ST_INIT_MRS: if (is_mrs && mrs_ok) state_d = ST_READY;
      default: ;
    endcase
  end

  // Init FSM: outputs
  always_comb begin
    ready    = in_ready;
    err      = err_q;
    err_code = err_code_q;
  end

  // Bank bookkeeping, mode register and error capture
  always_comb begin
    open_d     = open_q;
    row_d      = row_q;
    cl_d       = cl_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    flag       = 1'b0;
    flag_code  = 4'd0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
    for (int b = 0; b < 4; b++) begin
      trcd_cnt_d[b] = (trcd_cnt_q[b] != '0) ? trcd_cnt_q[b] - 1'b1 : trcd_cnt_q[b];
      trp_cnt_d[b]  = (trp_cnt_q[b]  != '0) ? trp_cnt_q[b]  - 1'b1 : trp_cnt_q[b];
    end
`endif
    if (is_act) begin
      if (!in_ready) begin
        flag = 1'b1; flag_code = 4'd1;
      end else if (open_q[ba]) begin
        flag = 1'b1; flag_code = 4'd3;
      end else begin
        open_d[ba] = 1'b1;
        row_d[ba]  = a;
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
        trcd_cnt_d[ba] = TRCD_LOAD;
        if (trp_cnt_q[ba] != '0) begin
          flag = 1'b1; flag_code = 4'd6;
        end
`endif
      end
    end
    if (is_rd || is_wr) begin
      if (!in_ready) begin
        flag = 1'b1; flag_code = 4'd1;
      end else if (!open_q[ba]) begin
        flag = 1'b1; flag_code = 4'd2;
      end else begin
        mem_we = is_wr;
        mem_re = is_rd;
        if (a[10]) open_d[ba] = 1'b0;
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
        if (a[10]) trp_cnt_d[ba] = TRP_LOAD;
        if (trcd_cnt_q[ba] != '0) begin
          flag = 1'b1; flag_code = 4'd5;
        end
`endif
      end
    end
    if (is_pre) begin
      for (int b = 0; b < 4; b++) begin
        if (a[10] || (ba == 2'(b))) begin
          open_d[b] = 1'b0;
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
          trp_cnt_d[b] = TRP_LOAD;
`endif
        end
      end
    end
    if (is_ref && (|open_q)) begin
      flag = 1'b1; flag_code = 4'd7;
    end
    if (is_mrs) begin
      if (mrs_ok) cl_d = (a[6:4] == 3'd3) ? 2'd3 : 2'd2;
      else begin
        flag = 1'b1; flag_code = 4'd4;
      end
    end
    if (flag && !err_q) begin
      err_d      = 1'b1;
      err_code_d = flag_code;
    end
  end

  // Read pipeline: slot 0 is on the bus; a READ lands in slot CL-1.
  always_comb begin
    rd_vld_d  = {1'b0, rd_vld_q[2:1]};
    rd_data_d = {16'h0000, rd_data_q[2:1]};
    rd_mask_d = {2'b00, rd_mask_q[2:1]};
    if (mem_re) begin
      if (cl_q == 2'd3) begin
        rd_vld_d[2] = 1'b1; rd_data_d[2] = rd_word; rd_mask_d[2] = dm;
      end else begin
        rd_vld_d[1] = 1'b1; rd_data_d[1] = rd_word; rd_mask_d[1] = dm;
      end
    end
    if (mem_we) rd_vld_d = 3'b000;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT_PRE;
      ref_seen_q <= 1'b0;
      cl_q       <= 2'd2;
      err_q      <= 1'b0;
      err_code_q <= 4'd0;
      open_q     <= 4'b0000;
      row_q      <= '0;
      rd_vld_q   <= 3'b000;
      rd_data_q  <= '0;
      rd_mask_q  <= '0;
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
      trcd_cnt_q <= '0;
      trp_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ref_seen_q <= ref_seen_d;
      cl_q       <= cl_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      open_q     <= open_d;
      row_q      <= row_d;
      rd_vld_q   <= rd_vld_d;
      rd_data_q  <= rd_data_d;
      rd_mask_q  <= rd_mask_d;
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
      trcd_cnt_q <= trcd_cnt_d;
      trp_cnt_q  <= trp_cnt_d;
`endif
    end
  end

  // Storage survives reset; writes cannot occur while in reset (FSM not ready).
  always_ff @(posedge clock) begin
    if (mem_we) begin
      if (!dm[0]) mem_q[word_idx][7:0]  <= dq[7:0];
      if (!dm[1]) mem_q[word_idx][15:8] <= dq[15:8];
    end
  end

  assign dq[7:0]  = (reset_n && rd_vld_q[0] && !rd_mask_q[0][0]) ? rd_data_q[0][7:0]  : 8'bz;
  assign dq[15:8] = (reset_n && rd_vld_q[0] && !rd_mask_q[0][1]) ? rd_data_q[0][15:8] : 8'bz;

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_responder
// Purpose  : Self-checking bench for sdram_responder with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_responder;

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [12:0] a;
  logic [1:0]  ba;
  logic        cs_n, ras_n, cas_n, we_n, cke;
  logic [1:0]  dm;
  tri1  [15:0] dq;
  logic        ready, err;
  logic [3:0]  err_code;

  logic        tb_drv;
  logic [15:0] tb_wdata;
  assign dq = tb_drv ? tb_wdata : 16'bz;

  sdram_responder dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .a        (a),
    .ba       (ba),
    .cs_n     (cs_n),
    .ras_n    (ras_n),
    .cas_n    (cas_n),
    .we_n     (we_n),
    .cke      (cke),
    .dm       (dm),
    .dq       (dq),
    .ready    (ready),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;
  exp_t sbq[$];

  // Reference model state (released bus reads as all-ones through the pull-up)
  logic [15:0] mdl [1024];
  logic [12:0] mrow [4];
  int          cl = 2;

  function automatic int widx(input logic [1:0] b, input logic [8:0] col);
    logic [23:0] f;
    f = {b, mrow[b], col};
    return int'(f[9:0]);
  endfunction

  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] ad,
                       input logic [1:0] m, input logic drv, input logic [15:0] wd);
    @(negedge clock);
    #1;
    {ras_n, cas_n, we_n} = c;
    cs_n = 1'b0; cke = 1'b1;
    ba = b; a = ad; dm = m;
    tb_drv = drv; tb_wdata = wd;
  endtask

  task automatic nop();
    issue(C_NOP, 2'd0, 13'd0, 2'b00, 1'b0, 16'h0000);
  endtask

  task automatic act(input logic [1:0] b, input logic [12:0] row);
    issue(C_ACT, b, row, 2'b00, 1'b0, 16'h0000);
    mrow[b] = row;
  endtask

  task automatic wr(input logic [1:0] b, input logic [8:0] col, input logic [15:0] d, input logic [1:0] m);
    int e, i;
    issue(C_WR, b, {4'b0000, col}, m, 1'b1, d);
    e = edge_cnt + 1;
    i = widx(b, col);
    if (!m[0]) mdl[i][7:0]  = d[7:0];
    if (!m[1]) mdl[i][15:8] = d[15:8];
    for (int k = sbq.size() - 1; k >= 0; k--)
      if (sbq[k].due >= e) sbq.delete(k);
  endtask

  task automatic rd(input logic [1:0] b, input logic [8:0] col, input logic [1:0] m);
    exp_t x;
    logic [15:0] w;
    issue(C_RD, b, {4'b0000, col}, m, 1'b0, 16'h0000);
    w = mdl[widx(b, col)];
    x.due = edge_cnt + 1 + cl;
    x.val = {m[1] ? 8'hFF : w[15:8], m[0] ? 8'hFF : w[7:0]};
    sbq.push_back(x);
  endtask

  task automatic init_seq();
    issue(C_PRE, 2'd0, 13'h0400, 2'b00, 1'b0, 16'h0000);
    issue(C_REF, 2'd0, 13'h0000, 2'b00, 1'b0, 16'h0000);
    issue(C_REF, 2'd0, 13'h0000, 2'b00, 1'b0, 16'h0000);
    issue(C_MRS, 2'd0, 13'h0020, 2'b00, 1'b0, 16'h0000);
    cl = 2;
    nop();
  endtask

  // Data monitor: every cycle the bus is either the scheduled read word or released.
  initial begin
    forever begin
      @(negedge clock);
      if (sbq.size() > 0 && sbq[0].due == edge_cnt + 1) begin
        check_val("rd_data", {16'h0, dq}, {16'h0, sbq[0].val});
        void'(sbq.pop_front());
      end else if (!tb_drv) begin
        check_val("dq_idle_z", {16'h0, dq}, 32'h0000FFFF);
      end
    end
  end

  initial begin
    reset_n = 1'b0; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    cke = 1'b1; a = '0; ba = '0; dm = '0; tb_drv = 1'b0; tb_wdata = '0;
    repeat (3) @(negedge clock);
    check_val("rst_ready", {31'h0, ready}, 32'd0);
    check_val("rst_err", {31'h0, err}, 32'd0);
    check_val("rst_code", {28'h0, err_code}, 32'd0);
    reset_n = 1'b1;

    // Access before init, then stickiness across a later error
    act(2'd0, 13'd1);
    nop();
    check_val("pre_init_err", {31'h0, err}, 32'd1);
    check_val("pre_init_code", {28'h0, err_code}, 32'd1);
    issue(C_PRE, 2'd0, 13'h0400, 2'b00, 1'b0, 16'h0000);
    issue(C_REF, 2'd0, 13'h0000, 2'b00, 1'b0, 16'h0000);
    issue(C_REF, 2'd0, 13'h0000, 2'b00, 1'b0, 16'h0000);
    check_val("one_ref_not_ready", {31'h0, ready}, 32'd0);
    issue(C_MRS, 2'd0, 13'h0020, 2'b00, 1'b0, 16'h0000);
    check_val("two_ref_not_ready", {31'h0, ready}, 32'd0);
    nop();
    check_val("init1_ready", {31'h0, ready}, 32'd1);
    act(2'd1, 13'd5);
    act(2'd1, 13'd5);
    nop();
    check_val("sticky_code", {28'h0, err_code}, 32'd1);

    // Reset clears status and banks but keeps CL back at 2
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check_val("rst2_err", {31'h0, err}, 32'd0);
    check_val("rst2_ready", {31'h0, ready}, 32'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    init_seq();
    check_val("init2_ready", {31'h0, ready}, 32'd1);
    check_val("init2_err", {31'h0, err}, 32'd0);

    // Basic write/read, CL=2
    act(2'd1, 13'd5);
    nop();
    wr(2'd1, 9'd3, 16'hBEEF, 2'b00);
    rd(2'd1, 9'd3, 2'b00);
    repeat (4) nop();

    // Byte masks on write and read
    wr(2'd1, 9'd3, 16'h1234, 2'b10);
    rd(2'd1, 9'd3, 2'b00);
    nop();
    rd(2'd1, 9'd3, 2'b01);
    repeat (4) nop();

    // Back-to-back reads
    wr(2'd1, 9'd4, 16'h5A5A, 2'b00);
    rd(2'd1, 9'd3, 2'b00);
    rd(2'd1, 9'd4, 2'b00);
    repeat (4) nop();
    check_val("data_err_clean", {31'h0, err}, 32'd0);

    // READ one cycle after ACTIVE
    act(2'd2, 13'd7);
    rd(2'd2, 9'd4, 2'b00);
    repeat (4) nop();
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
    check_val("trcd_err", {31'h0, err}, 32'd1);
    check_val("trcd_code", {28'h0, err_code}, 32'd5);
`else
    check_val("trcd_err", {31'h0, err}, 32'd0);
    check_val("trcd_code", {28'h0, err_code}, 32'd0);
`endif

    // CL=3: write cancels a pending read, then a plain CL=3 read
    issue(C_MRS, 2'd0, 13'h0030, 2'b00, 1'b0, 16'h0000);
    cl = 3;
    nop();
    rd(2'd1, 9'd4, 2'b00);
    wr(2'd1, 9'd3, 16'h0F0F, 2'b00);
    repeat (5) nop();
    rd(2'd1, 9'd3, 2'b00);
    repeat (5) nop();
    check_val("sb_drain", sbq.size(), 32'd0);

    // Reset while the responder is driving
    rd(2'd1, 9'd4, 2'b00);
    nop();
    nop();
    @(posedge clock);
    #2;
    check_val("mid_read_dq", {16'h0, dq}, 32'h00005A5A);
    sbq.delete();
    reset_n = 1'b0;
    #1;
    check_val("rst_release_dq", {16'h0, dq}, 32'h0000FFFF);
    check_val("rst_release_ready", {31'h0, ready}, 32'd0);
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
